// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state constants shared by alu_seq and alu_muldiv_iter
package alu_pkg;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider
// Ports: clk, rst_n (sync, active-low); start loads op/a/b and begins WIDTH iterations;
// done is high during the last iteration, when result/rem/overflow already show the final values.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int CW = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] rem,
   output logic             overflow
);
   logic                 busy_q, div_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   acc_q, acc_d, mc_q;
   logic [WIDTH-1:0]     mp_q, quo_q, quo_d, dvs_q, prem_q, prem_d;
   logic [WIDTH:0]       shifted, trial;
   // The partial remainder is WIDTH+1 bits wide only transiently: after restoring it always fits
   // in WIDTH bits, and the sign of the trial subtraction decides the quotient bit.
   always_comb begin
      acc_d   = acc_q + (mp_q[0] ? mc_q : '0);
      shifted = {prem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
      prem_d  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], !trial[WIDTH]};
   end
   assign done     = busy_q && cnt_q == CW'(WIDTH - 1);
   assign result   = div_q ? quo_d : acc_d[WIDTH-1:0];
   assign rem      = div_q ? prem_d : '0;
   assign overflow = !div_q && |acc_d[2*WIDTH-1:WIDTH];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         mc_q   <= '0;
         mp_q   <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         prem_q <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         div_q  <= op == OP_DIV;
         cnt_q  <= '0;
         acc_q  <= '0;
         mc_q   <= {{WIDTH{1'b0}}, a};
         mp_q   <= b;
         quo_q  <= a;
         dvs_q  <= b;
         prem_q <= '0;
      end else if (busy_q) begin
         busy_q <= !done;
         cnt_q  <= cnt_q + CW'(1);
         acc_q  <= acc_d;
         mc_q   <= mc_q << 1;
         mp_q   <= mp_q >> 1;
         quo_q  <= quo_d;
         prem_q <= prem_d;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multicycle unsigned add/sub/mul/div ALU with valid/ready handshakes
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with ina, inb, sel accept an operation;
// out_valid/out_ready present result, rem, overflow and div_zero, held stable until taken.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] rem,
   output logic             overflow,
   output logic             div_zero
);
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d, rem_q, rem_d, iter_res, iter_rem;
   logic             ovf_q, ovf_d, dz_q, dz_d, iter_ovf, iter_done;
   logic [WIDTH:0]   sum, diff;
   logic             accept, dz_now, iter_start;
   assign in_ready   = state_q == ST_IDLE;
   assign out_valid  = state_q == ST_DONE;
   assign accept     = in_valid && in_ready;
   assign dz_now     = sel == OP_DIV && inb == '0;
   // Divide by zero bypasses the iterative unit and finishes like add/sub.
   assign iter_start = accept && sel[1] && !dz_now;
   assign sum        = {1'b0, ina} + {1'b0, inb};
   assign diff       = {1'b0, ina} - {1'b0, inb};
   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (iter_start),
      .op       (sel),
      .a        (ina),
      .b        (inb),
      .done     (iter_done),
      .result   (iter_res),
      .rem      (iter_rem),
      .overflow (iter_ovf)
   );
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      if (accept && !iter_start) begin
         state_d = ST_DONE;
         res_d   = dz_now ? '1 : sel[0] ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
         rem_d   = dz_now ? ina : '0;
         ovf_d   = !sel[1] && (sel[0] ? diff[WIDTH] : sum[WIDTH]);
         dz_d    = dz_now;
      end else if (iter_start) begin
         state_d = ST_CALC;
      end else if (state_q == ST_CALC && iter_done) begin
         state_d = ST_DONE;
         res_d   = iter_res;
         rem_d   = iter_rem;
         ovf_d   = iter_ovf;
         dz_d    = 1'b0;
      end else if (state_q == ST_DONE && out_ready) begin
         state_d = ST_IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end
   assign result   = res_q;
   assign rem      = rem_q;
   assign overflow = ovf_q;
   assign div_zero = dz_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multicycle successor to the team's combinational 16-bit four-function ALU. It provides add, subtract, multiply and divide at WIDTH bits. Add and subtract complete in a single cycle; multiply (shift-add) and divide (restoring) are iterative. Operands enter and results leave through valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage that may stall.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 2..64.
CW, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept an operation
ina  input  WIDTH  operand A (unsigned)
inb  input  WIDTH  operand B (unsigned)
sel  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference/low product/quotient
rem  output  WIDTH  division remainder; 0 for other ops
overflow  output  1  carry, borrow or product overflow
div_zero  output  1  divide by zero flagged

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge) returns the FSM to IDLE. Outputs after reset:
  - in_ready=1.
  - out_valid=0, result=0, rem=0, overflow=0, div_zero=0.
  - Reset overrides everything, including an operation in flight. The partial result is discarded and not presented.
- FSM states are IDLE, CALC and DONE.
  - in_ready = (state==IDLE).
  - Accept occurs when in_valid && in_ready. At accept, ina, inb and sel are latched; later input changes are ignored.
  - IDLE, accept with add/sub: go to DONE, out_valid=1 on the next cycle (latency 1).
  - IDLE, accept with div and inb==0: go to DONE with latency 1. Outputs are result = all ones, rem = ina, div_zero=1, overflow=0.
  - IDLE, accept with mul, or div with inb!=0: go to CALC with counter=0. Each CALC cycle processes one bit. After WIDTH iterations go to DONE, so out_valid rises exactly WIDTH+1 cycles after accept.
  - DONE: hold out_valid=1 and keep all outputs stable until out_ready=1. On out_valid && out_ready, go to IDLE; out_valid=0 and in_ready=1 on the next cycle.
  - There is no same-cycle turnaround: minimum issue interval is 2 cycles for add/sub and WIDTH+2 for mul/div.
- Arithmetic (all unsigned, WIDTH-bit):
  - add: result = (ina+inb) mod 2^WIDTH; overflow = carry out.
  - sub: result = (ina-inb) mod 2^WIDTH; overflow = borrow (ina<inb).
  - mul: internal 2*WIDTH-bit accumulator. result = low WIDTH bits; overflow = |high WIDTH bits.
  - div: restoring division with a WIDTH+1-bit partial remainder. result = quotient, rem = remainder, overflow=0.
  - rem=0 for add, sub and mul. div_zero=0 except in the divide-by-zero case.
- Outputs are registered and change only when entering DONE or at reset.
- An in_valid pulse while in_ready=0 is not accepted and is not queued. The producer holds in_valid until accepted.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - FSM state encoding ST_IDLE, ST_CALC, ST_DONE.
- Sub-module alu_muldiv_iter holds the iterative datapath: product/remainder shift registers and the CW-bit counter.
  - Driven by start, op and the operands; returns done, result, rem and overflow.
- alu_seq keeps the FSM, the handshake, the single-cycle add/sub and the output registers.

Test Plan:
- Add/sub (WIDTH=16):
  - add 0xFFFF+0x0001 -> result=0x0000, overflow=1, out_valid exactly 1 cycle after accept.
  - sub 0x0003-0x0005 -> result=0xFFFE, overflow=1, rem=0.
- Multiply (WIDTH=16):
  - mul 0x00FF*0x0101 -> result=0xFFFF, overflow=0.
  - mul 0x0100*0x0100 -> result=0x0000, overflow=1.
  - In both cases out_valid rises exactly 17 cycles after accept and in_ready=0 throughout.
- Divide:
  - div 100/7 -> result=14, rem=2, div_zero=0, latency 17.
  - div 0x1234/0 -> result=0xFFFF, rem=0x1234, div_zero=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a mul result. result, overflow and out_valid stay stable, and in_ready stays 0. A new in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-operation: drive rst_n=0 at CALC iteration 8 of a div. On the next cycle all outputs are 0 and in_ready=1. A subsequent add 2+3 returns 5 with no stale data.
- Parameter sweep: repeat the scenarios at WIDTH=8 (latency 9; mul 0x10*0x10 -> 0x00, overflow=1) and WIDTH=32. Check randomized ops against a reference model.
